seq_control: RTL and testbench
==============================

SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit, a synchronous active-high reset sampled on the rising edge of clock.
REQ-003 The block SHALL have the port mem_ack, input, 1 bit, meaning instruction memory has valid data on instr this cycle.
REQ-004 The block SHALL have the port instr, input, 8 bits: opcode in [7:4], operand/target in [3:0].
REQ-005 The block SHALL have the port carry, input, 1 bit, the ULA carry flag, sampled in EXEC.
REQ-006 The block SHALL have the port step, input, 1 bit, a single-step advance pulse; it is present only with SEQ_STEP_EN.
REQ-007 The block SHALL have the port mem_req, output, 1 bit, the instruction fetch request.
REQ-008 The block SHALL have the port pc_inc, output, 1 bit, a one-cycle PC increment pulse.
REQ-009 The block SHALL have the port pc_load, output, 1 bit, a one-cycle PC load pulse.
REQ-010 The block SHALL have the port pc_target, output, 4 bits, equal to ir[3:0].
REQ-011 The block SHALL have the ports jump, jumpc, sin, ina, twone, outputs, 1 bit each, the accumulator-control strobes, asserted for one cycle.
REQ-012 The block SHALL have the port operand, output, 4 bits, equal to ir[3:0].
REQ-013 The block SHALL have the port halted, output, 1 bit, high in state HALT.
REQ-014 The block SHALL have the port instr_count, output, 8 bits, the count of retired instructions.

Function
REQ-015 The block SHALL implement the states FETCH, DECODE, EXEC and HALT, plus PAUSE when SEQ_STEP_EN is defined.
REQ-016 In FETCH, the block SHALL hold mem_req high until mem_ack is seen; it SHALL wait indefinitely with no timeout.
REQ-017 In the FETCH cycle with mem_ack=1, the block SHALL load ir from instr, pulse pc_inc, and go to DECODE next cycle.
REQ-018 DECODE SHALL last exactly 1 cycle, with all strobes low, and then go to EXEC.
REQ-019 EXEC SHALL last exactly 1 cycle and assert strobes from ir[7:4] as follows:
- 0x0 NOP: none.
- 0x1 LDA: sin.
- 0x2 ADD: twone, with ina=0.
- 0x3 ADDIN: twone, with ina=1.
- 0x4 JMP: jump and pc_load.
- 0x5 JC: jumpc always; pc_load only if carry=1.
- 0xF HLT: none.
- 0x6 to 0xE: treated as NOP.
REQ-020 The latency of an instruction with an immediate mem_ack SHALL be 3 cycles, measured from the rising edge of mem_req to the retirement of that instruction.
REQ-021 On EXEC exit, instr_count SHALL increment by 1 and wrap from 0xFF to 0x00; HLT also counts.
REQ-022 After EXEC, the next state SHALL be HALT for opcode 0xF, otherwise FETCH (or PAUSE under SEQ_STEP_EN).
REQ-023 HALT SHALL be left only by reset; all strobes, mem_req and pc_* SHALL be low in HALT.
REQ-024 At most one of jump, jumpc, sin or twone SHALL be high in any cycle, and all SHALL be low outside EXEC.
REQ-025 A mem_ack arriving outside FETCH SHALL be ignored.

Reset
REQ-026 With reset=1 at a clock edge, the next state SHALL be FETCH, and ir, instr_count and all outputs SHALL be 0; reset has priority over every other event.
REQ-027 A reset asserted mid-instruction (DECODE or EXEC) SHALL abort that instruction with no pc_load and no count increment in that cycle.
REQ-028 mem_req SHALL rise in the first cycle after reset is deasserted.

Configuration
REQ-029 When the macro SEQ_STEP_EN is defined, the step port SHALL exist and EXEC SHALL go to PAUSE, which waits until step=1 and then goes to FETCH the next cycle.
REQ-030 A step pulse that arrives outside PAUSE SHALL be ignored.
REQ-031 When SEQ_STEP_EN is undefined, the step port and the PAUSE state SHALL be absent, and EXEC SHALL go directly to FETCH.

Structure
REQ-032 A shared package seq_pkg SHALL hold the state enum and the opcode constants OP_NOP, OP_LDA, OP_ADD, OP_ADDIN, OP_JMP, OP_JC and OP_HLT.
REQ-033 A sub-module seq_decode SHALL provide the combinational mapping from opcode and carry to the strobe vector; the FSM, ir and counter SHALL stay in seq_control.

Verification
REQ-034 The bench SHALL check the following directed scenarios:
- Reset, then fetch 0x2 with mem_ack held 1 -> mem_req high in cycle 1, pc_inc in cycle 1, twone=1 and ina=0 in cycle 3, instr_count=1.
- Fetch 0x57 with carry=0 -> jumpc=1, pc_load=0; repeat with carry=1 -> pc_load=1 and pc_target=0x7.
- mem_ack delayed 5 cycles -> mem_req held high for 6 cycles with no strobes; then normal completion.
- Opcode 0xF0 -> halted=1 from the following cycle; further mem_ack and step have no effect; reset restores FETCH.
- 256 NOPs -> instr_count wraps to 0x00; reset asserted during EXEC -> no increment and all outputs 0.
- With SEQ_STEP_EN defined -> FSM stays in PAUSE with mem_req=0 until step=1, then mem_req rises the next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and opcodes for the instruction sequencer.
// SEQ_STEP_EN adds the PAUSE state used for single-stepping.
package seq_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    HALT
`ifdef SEQ_STEP_EN
    , PAUSE
`endif
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDA   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_ADDIN = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_JC    = 4'h5;
  localparam logic [3:0] OP_HLT   = 4'hF;

  typedef struct packed {
    logic jump;
    logic jumpc;
    logic sin;
    logic ina;
    logic twone;
    logic pcLoad;
  } strobe_t;

endpackage

// File: rtl/seq_decode.sv
// Opcode/carry to accumulator and PC strobe mapping.
// Strobes are only produced while en is high (EXEC cycle).
module seq_decode
  import seq_pkg::*;
(
  input  logic       en,
  input  logic [3:0] opcode,
  input  logic       carry,
  output strobe_t    strobes
);

  always_comb begin
    strobes = '0;
    if (en) begin
      unique case (1'b1)
        (opcode == OP_LDA): strobes.sin = 1'b1;
        (opcode == OP_ADD): strobes.twone = 1'b1;
        (opcode == OP_ADDIN): begin
          strobes.twone = 1'b1;
          strobes.ina   = 1'b1;
        end
        (opcode == OP_JMP): begin
          strobes.jump   = 1'b1;
          strobes.pcLoad = 1'b1;
        end
        (opcode == OP_JC): begin
          strobes.jumpc  = 1'b1;
          strobes.pcLoad = carry;
        end
        default: strobes = '0;
      endcase
    end
  end

endmodule

// File: rtl/seq_control.sv
// Fetch/decode/execute sequencer with instruction retire counter.
// Define SEQ_STEP_EN to add the step port and PAUSE state.
module seq_control
  import seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       mem_ack,
  input  logic [7:0] instr,
  input  logic       carry,
`ifdef SEQ_STEP_EN
  input  logic       step,
`endif
  output logic       mem_req,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [3:0] pc_target,
  output logic       jump,
  output logic       jumpc,
  output logic       sin,
  output logic       ina,
  output logic       twone,
  output logic [3:0] operand,
  output logic       halted,
  output logic [7:0] instr_count
);

  state_t     state;
  state_t     stateNext;
  logic [7:0] ir;
  logic [7:0] count;
  logic       inExec;
  strobe_t    strobes;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      ir    <= '0;
      count <= '0;
    end else begin
      state <= stateNext;
      if (state == FETCH && mem_ack) ir <= instr;
      if (state == EXEC) count <= count + 8'd1;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      FETCH:  if (mem_ack) stateNext = DECODE;
      DECODE: stateNext = EXEC;
      EXEC: begin
        if (ir[7:4] == OP_HLT) stateNext = HALT;
`ifdef SEQ_STEP_EN
        else stateNext = PAUSE;
`else
        else stateNext = FETCH;
`endif
      end
      HALT:   stateNext = HALT;
`ifdef SEQ_STEP_EN
      PAUSE:  if (step) stateNext = FETCH;
`endif
      default: stateNext = FETCH;
    endcase
  end

  // Reset gates the strobes so an aborted instruction has no effect.
  assign inExec = !reset && (state == EXEC);

  seq_decode uDecode (
    .en      (inExec),
    .opcode  (ir[7:4]),
    .carry   (carry),
    .strobes (strobes)
  );

  always_comb begin
    mem_req = !reset && (state == FETCH);
    pc_inc  = !reset && (state == FETCH) && mem_ack;
    halted  = !reset && (state == HALT);
    pc_load = strobes.pcLoad;
    jump    = strobes.jump;
    jumpc   = strobes.jumpc;
    sin     = strobes.sin;
    ina     = strobes.ina;
    twone   = strobes.twone;
  end

  assign pc_target   = ir[3:0];
  assign operand     = ir[3:0];
  assign instr_count = count;

endmodule

// File: tb/tb_seq_control.sv
// Randomized transaction-level bench for seq_control.
// Builds with or without SEQ_STEP_EN.
module tb_seq_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ack = 1'b0;
  logic [7:0] instr = '0;
  logic       carry = 1'b0;
  logic       step = 1'b0;
  logic       mem_req;
  logic       pc_inc;
  logic       pc_load;
  logic [3:0] pc_target;
  logic       jump;
  logic       jumpc;
  logic       sin;
  logic       ina;
  logic       twone;
  logic [3:0] operand;
  logic       halted;
  logic [7:0] instr_count;

  int         nCompared = 0;
  int         nMismatched = 0;
  logic [7:0] mCount = '0;

  always #5 clock = ~clock;

  seq_control dut (
    .clock       (clock),
    .reset       (reset),
    .mem_ack     (mem_ack),
    .instr       (instr),
    .carry       (carry),
`ifdef SEQ_STEP_EN
    .step        (step),
`endif
    .mem_req     (mem_req),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .jump        (jump),
    .jumpc       (jumpc),
    .sin         (sin),
    .ina         (ina),
    .twone       (twone),
    .operand     (operand),
    .halted      (halted),
    .instr_count (instr_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // {jump, jumpc, sin, ina, twone, pc_load}
  function automatic logic [5:0] expStrobes(
    input logic [7:0] op, input logic c);
    case (op[7:4])
      4'h1:    return 6'b001000;
      4'h2:    return 6'b000010;
      4'h3:    return 6'b000110;
      4'h4:    return 6'b100001;
      4'h5:    return {5'b01000, c};
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] gotStrobes();
    return {jump, jumpc, sin, ina, twone, pc_load};
  endfunction

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    mem_ack = 1'($urandom);
    step    = 1'($urandom);
    nextCycle();
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_out", {gotStrobes(), pc_inc, halted}, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_operand", {operand, pc_target}, 0);
    mCount = '0;
    reset  = 1'b0;
  endtask

  task automatic runInstr(input logic [7:0] op,
                          input int delay,
                          input logic c,
                          input int abortAt);
    int n;
    for (int i = 0; i <= delay; i++) begin
      mem_ack = (i == delay);
      instr   = (i == delay) ? op : 8'($urandom);
      carry   = 1'($urandom);
      step    = 1'($urandom);
      #1;
      chk("fetch_req", mem_req, 1);
      chk("fetch_inc", pc_inc, (i == delay));
      chk("fetch_strb", gotStrobes(), 0);
      chk("fetch_halt", halted, 0);
      nextCycle();
    end
    mem_ack = 1'($urandom);
    instr   = 8'($urandom);
    carry   = 1'($urandom);
    step    = 1'($urandom);
    if (abortAt == 2) reset = 1'b1;
    #1;
    chk("dec_req", mem_req, 0);
    chk("dec_inc", pc_inc, 0);
    chk("dec_strb", gotStrobes(), 0);
    if (abortAt == 2) begin
      doReset();
      return;
    end
    nextCycle();
    mem_ack = 1'($urandom);
    instr   = 8'($urandom);
    carry   = c;
    step    = 1'($urandom);
    if (abortAt == 3) reset = 1'b1;
    #1;
    chk("exec_strb", gotStrobes(),
        (abortAt == 3) ? 6'b0 : expStrobes(op, c));
    chk("exec_req", {mem_req, pc_inc}, 0);
    chk("exec_target", pc_target, op[3:0]);
    chk("exec_operand", operand, op[3:0]);
    chk("exec_count", instr_count, mCount);
    if (abortAt == 3) begin
      doReset();
      return;
    end
    nextCycle();
    mCount = mCount + 8'd1;
    chk("retire_count", instr_count, mCount);
    if (op[7:4] == 4'hF) begin
      for (int k = 0; k < 4; k++) begin
        mem_ack = 1'b1;
        step    = 1'($urandom);
        instr   = 8'($urandom);
        #1;
        chk("halt_flag", halted, 1);
        chk("halt_req", {mem_req, pc_inc}, 0);
        chk("halt_strb", gotStrobes(), 0);
        chk("halt_count", instr_count, mCount);
        nextCycle();
      end
      doReset();
    end else begin
`ifdef SEQ_STEP_EN
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        step    = 1'b0;
        mem_ack = 1'($urandom);
        #1;
        chk("pause_req", {mem_req, pc_inc}, 0);
        chk("pause_strb", gotStrobes(), 0);
        nextCycle();
      end
      step    = 1'b1;
      mem_ack = 1'($urandom);
      #1;
      chk("pause_step_req", mem_req, 0);
      chk("pause_halt", halted, 0);
      nextCycle();
      step = 1'b0;
`else
      n = 0;
`endif
    end
  endtask

  initial begin
    logic [7:0] op;
    int         abortAt;

    doReset();
    runInstr(8'h20, 0, 1'b0, 0);
    chk("dir_add_count", instr_count, 1);
    runInstr(8'h57, 0, 1'b0, 0);
    runInstr(8'h57, 0, 1'b1, 0);
    runInstr(8'h13, 5, 1'b0, 0);
    runInstr(8'h4A, 0, 1'b0, 3);
    runInstr(8'h3C, 0, 1'b1, 2);
    runInstr(8'h3C, 0, 1'b1, 0);
    runInstr(8'hF0, 0, 1'b0, 0);

    for (int i = 0; i < 256; i++)
      runInstr({4'h0, 4'($urandom)}, 0, 1'($urandom), 0);
    chk("nop_wrap", instr_count, 0);

    for (int i = 0; i < 200; i++) begin
      op = 8'($urandom);
      abortAt = ($urandom_range(0, 19) == 0) ?
                $urandom_range(2, 3) : 0;
      runInstr(op, $urandom_range(0, 3),
               1'($urandom), abortAt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule
